// File: rtl/pipe_ctrl_unit.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_ctrl_unit
//  Purpose  : Decode-stage control unit. Decodes op/funct into a registered
//             control bundle (one cycle latency), supports stall/flush, and
//             runs a RUN -> DRAIN -> HALT sequence after an end instruction.
//  Ports    : clk      - clock, rising edge
//             rst      - asynchronous active-low reset
//             op       - [5:0] opcode of the instruction in decode
//             funct    - [5:0] funct field of the instruction in decode
//             valid    - op/funct hold a real instruction
//             stall    - hold all registered outputs
//             flush    - load a bubble on the next edge
//             bneD, Jreg, Jump, MemReadD, JalWrite, SftD, RegWriteD,
//             MemtoRegD, MemWriteD, BranchD, ALUSrcD, RegDstD, EndD, LuiD
//                      - registered control bundle bits
//             ALUctrD  - [ALUW-1:0] registered ALU operation code
//             illegal  - one-cycle pulse on an unrecognised valid instruction
//             halt     - level, program finished and pipeline drained
//  Revision : 1.0 - initial release
// ============================================================================
module pipe_ctrl_unit #(
    parameter int ALUW   = 4,
    parameter int DRAIN  = 4,
    parameter int EXT_EN = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [5:0]      op,
    input  logic [5:0]      funct,
    input  logic            valid,
    input  logic            stall,
    input  logic            flush,
    output logic            bneD,
    output logic            Jreg,
    output logic            Jump,
    output logic            MemReadD,
    output logic            JalWrite,
    output logic            SftD,
    output logic            RegWriteD,
    output logic            MemtoRegD,
    output logic            MemWriteD,
    output logic            BranchD,
    output logic [ALUW-1:0] ALUctrD,
    output logic            ALUSrcD,
    output logic            RegDstD,
    output logic            EndD,
    output logic            LuiD,
    output logic            illegal,
    output logic            halt
);

    // Sequencer states
    localparam logic [1:0] c_ST_RUN   = 2'd0;
    localparam logic [1:0] c_ST_DRAIN = 2'd1;
    localparam logic [1:0] c_ST_HALT  = 2'd2;

    localparam logic [7:0] c_DRAIN_LOAD = 8'(DRAIN);
    localparam logic       c_EXT        = (EXT_EN != 0);

    // ALU operation codes
    localparam logic [3:0] c_ALU_ADD = 4'd0;
    localparam logic [3:0] c_ALU_SUB = 4'd1;
    localparam logic [3:0] c_ALU_AND = 4'd2;
    localparam logic [3:0] c_ALU_NOR = 4'd3;
    localparam logic [3:0] c_ALU_OR  = 4'd4;
    localparam logic [3:0] c_ALU_XOR = 4'd5;
    localparam logic [3:0] c_ALU_SLL = 4'd6;
    localparam logic [3:0] c_ALU_SRL = 4'd7;
    localparam logic [3:0] c_ALU_SRA = 4'd8;
    localparam logic [3:0] c_ALU_SLT = 4'd9;
    localparam logic [3:0] c_ALU_BNE = 4'd10;

    // Opcodes
    localparam logic [5:0] c_OP_R     = 6'b000000;
    localparam logic [5:0] c_OP_J     = 6'b000010;
    localparam logic [5:0] c_OP_JAL   = 6'b000011;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_BNE   = 6'b000101;
    localparam logic [5:0] c_OP_ADDI  = 6'b001000;
    localparam logic [5:0] c_OP_ADDIU = 6'b001001;
    localparam logic [5:0] c_OP_SLTI  = 6'b001010;
    localparam logic [5:0] c_OP_ANDI  = 6'b001100;
    localparam logic [5:0] c_OP_ORI   = 6'b001101;
    localparam logic [5:0] c_OP_XORI  = 6'b001110;
    localparam logic [5:0] c_OP_LUI   = 6'b001111;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;
    localparam logic [5:0] c_OP_END   = 6'b111111;

    typedef struct packed {
        logic       bne;
        logic       jreg;
        logic       jump;
        logic       memRead;
        logic       jalWrite;
        logic       sft;
        logic       regWrite;
        logic       memtoReg;
        logic       memWrite;
        logic       branch;
        logic       aluSrc;
        logic       regDst;
        logic       endI;
        logic       lui;
        logic [3:0] alu;
    } bundle_t;

    logic [1:0] r_state;
    logic [7:0] r_cnt;
    bundle_t    r_bun;
    logic       r_illegal;
    logic       r_halt;

    bundle_t    w_dec;
    logic       w_known;
    bundle_t    w_load;

    // ------------------------------------------------------------------
    // Combinational decode of op/funct
    // ------------------------------------------------------------------
    always_comb begin
        w_dec   = '0;
        w_known = 1'b1;
        case (op)
            c_OP_R: begin
                w_dec.regWrite = 1'b1;
                w_dec.regDst   = 1'b1;
                case (funct)
                    6'b100000, 6'b100001: w_dec.alu = c_ALU_ADD;
                    6'b100010, 6'b100011: w_dec.alu = c_ALU_SUB;
                    6'b100100: w_dec.alu = c_ALU_AND;
                    6'b100111: w_dec.alu = c_ALU_NOR;
                    6'b100101: w_dec.alu = c_ALU_OR;
                    6'b100110: w_dec.alu = c_ALU_XOR;
                    6'b101010: w_dec.alu = c_ALU_SLT;
                    6'b000100: w_dec.alu = c_ALU_SLL;
                    6'b000110: w_dec.alu = c_ALU_SRL;
                    6'b000111: w_dec.alu = c_ALU_SRA;
                    6'b000000: begin w_dec.alu = c_ALU_SLL; w_dec.sft = 1'b1; end
                    6'b000010: begin w_dec.alu = c_ALU_SRL; w_dec.sft = 1'b1; end
                    6'b000011: begin w_dec.alu = c_ALU_SRA; w_dec.sft = 1'b1; end
                    6'b001000: begin
                        // jr writes nothing back
                        w_dec.regWrite = 1'b0;
                        w_dec.regDst   = 1'b0;
                        w_dec.jreg     = 1'b1;
                    end
                    6'b001001: begin
                        w_dec.regDst   = 1'b0;
                        w_dec.jreg     = 1'b1;
                        w_dec.jalWrite = 1'b1;
                        w_known        = c_EXT;
                    end
                    default: w_known = 1'b0;
                endcase
            end
            c_OP_ADDI, c_OP_ADDIU: begin
                w_dec.aluSrc = 1'b1; w_dec.regWrite = 1'b1; w_dec.alu = c_ALU_ADD;
            end
            c_OP_ANDI: begin
                w_dec.aluSrc = 1'b1; w_dec.regWrite = 1'b1; w_dec.alu = c_ALU_AND;
            end
            c_OP_ORI: begin
                w_dec.aluSrc = 1'b1; w_dec.regWrite = 1'b1; w_dec.alu = c_ALU_OR;
            end
            c_OP_XORI: begin
                w_dec.aluSrc = 1'b1; w_dec.regWrite = 1'b1; w_dec.alu = c_ALU_XOR;
            end
            c_OP_SLTI: begin
                w_dec.aluSrc = 1'b1; w_dec.regWrite = 1'b1; w_dec.alu = c_ALU_SLT;
                w_known = c_EXT;
            end
            c_OP_LUI: begin
                w_dec.lui = 1'b1; w_dec.aluSrc = 1'b1; w_dec.regWrite = 1'b1;
                w_known = c_EXT;
            end
            c_OP_LW: begin
                w_dec.memRead  = 1'b1; w_dec.regWrite = 1'b1;
                w_dec.memtoReg = 1'b1; w_dec.aluSrc   = 1'b1;
            end
            c_OP_SW: begin
                w_dec.memWrite = 1'b1; w_dec.aluSrc = 1'b1;
            end
            c_OP_BEQ: begin
                w_dec.branch = 1'b1; w_dec.alu = c_ALU_SUB;
            end
            c_OP_BNE: begin
                w_dec.branch = 1'b1; w_dec.bne = 1'b1;
                w_dec.regDst = 1'b1; w_dec.alu = c_ALU_BNE;
            end
            c_OP_J:   w_dec.jump = 1'b1;
            c_OP_JAL: begin
                w_dec.jump = 1'b1; w_dec.jalWrite = 1'b1; w_dec.regWrite = 1'b1;
            end
            c_OP_END: w_dec.endI = 1'b1;
            default:  w_known = 1'b0;
        endcase
    end

    // Invalid slots and unrecognised encodings both become bubbles
    assign w_load = (valid && w_known) ? w_dec : '0;

    // ------------------------------------------------------------------
    // Bundle register and RUN/DRAIN/HALT sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= c_ST_RUN;
            r_cnt     <= 8'd0;
            r_bun     <= '0;
            r_illegal <= 1'b0;
            r_halt    <= 1'b0;
        end else begin
            r_illegal <= 1'b0;
            case (r_state)
                c_ST_RUN: begin
                    if (flush) begin
                        r_bun <= '0;
                    end else if (!stall) begin
                        r_bun     <= w_load;
                        r_illegal <= valid && !w_known;
                        if (w_load.endI) begin
                            r_state <= c_ST_DRAIN;
                            r_cnt   <= c_DRAIN_LOAD;
                        end
                    end
                end
                c_ST_DRAIN: begin
                    // flush only changes the bundle; counter follows stall alone
                    if (flush || !stall) begin
                        r_bun <= '0;
                    end
                    if (!stall) begin
                        if (r_cnt == 8'd1) begin
                            r_state <= c_ST_HALT;
                            r_cnt   <= 8'd0;
                        end else begin
                            r_cnt <= r_cnt - 8'd1;
                        end
                    end
                end
                c_ST_HALT: begin
                    // halt rises one edge after HALT is entered, so exactly
                    // DRAIN bubble cycles separate EndD from halt
                    r_bun  <= '0;
                    r_halt <= 1'b1;
                end
                default: begin
                    r_state <= c_ST_RUN;
                    r_bun   <= '0;
                end
            endcase
        end
    end

    assign bneD      = r_bun.bne;
    assign Jreg      = r_bun.jreg;
    assign Jump      = r_bun.jump;
    assign MemReadD  = r_bun.memRead;
    assign JalWrite  = r_bun.jalWrite;
    assign SftD      = r_bun.sft;
    assign RegWriteD = r_bun.regWrite;
    assign MemtoRegD = r_bun.memtoReg;
    assign MemWriteD = r_bun.memWrite;
    assign BranchD   = r_bun.branch;
    assign ALUctrD   = ALUW'(r_bun.alu);
    assign ALUSrcD   = r_bun.aluSrc;
    assign RegDstD   = r_bun.regDst;
    assign EndD      = r_bun.endI;
    assign LuiD      = r_bun.lui;
    assign illegal   = r_illegal;
    assign halt      = r_halt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_ctrl_unit
//  Purpose  : Self-checking bench for pipe_ctrl_unit. Table of decode vectors
//             plus hand sequences for drain, halt, stall/flush and reset.
//             Expected bundles are queued when stimulus is driven and popped
//             when the registered outputs are sampled.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_ctrl_unit;

    localparam int ALUW = 4;

    // Flag bit positions in {bneD,Jreg,Jump,MemReadD,JalWrite,SftD,RegWriteD,
    // MemtoRegD,MemWriteD,BranchD,ALUSrcD,RegDstD,EndD,LuiD}
    localparam logic [13:0] c_BNE  = 14'd1 << 13;
    localparam logic [13:0] c_JREG = 14'd1 << 12;
    localparam logic [13:0] c_JMP  = 14'd1 << 11;
    localparam logic [13:0] c_MR   = 14'd1 << 10;
    localparam logic [13:0] c_JAL  = 14'd1 << 9;
    localparam logic [13:0] c_SFT  = 14'd1 << 8;
    localparam logic [13:0] c_RW   = 14'd1 << 7;
    localparam logic [13:0] c_M2R  = 14'd1 << 6;
    localparam logic [13:0] c_MW   = 14'd1 << 5;
    localparam logic [13:0] c_BR   = 14'd1 << 4;
    localparam logic [13:0] c_SRC  = 14'd1 << 3;
    localparam logic [13:0] c_RD   = 14'd1 << 2;
    localparam logic [13:0] c_END  = 14'd1 << 1;
    localparam logic [13:0] c_LUI  = 14'd1 << 0;
    localparam logic [13:0] c_NONE = 14'd0;
    localparam logic [13:0] c_RR   = c_RW | c_RD;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [5:0] op = 6'd0;
    logic [5:0] funct = 6'd0;
    logic       valid = 1'b0;
    logic       stall = 1'b0;
    logic       flush = 1'b0;

    logic bneD, Jreg, Jump, MemReadD, JalWrite, SftD, RegWriteD, MemtoRegD;
    logic MemWriteD, BranchD, ALUSrcD, RegDstD, EndD, LuiD, illegal, halt;
    logic [ALUW-1:0] ALUctrD;

    logic bneD2, Jreg2, Jump2, MemReadD2, JalWrite2, SftD2, RegWriteD2, MemtoRegD2;
    logic MemWriteD2, BranchD2, ALUSrcD2, RegDstD2, EndD2, LuiD2, illegal2, halt2;
    logic [ALUW-1:0] ALUctrD2;

    pipe_ctrl_unit #(.ALUW(ALUW), .DRAIN(4), .EXT_EN(1)) u_dut (
        .clk(clk), .rst(rst), .op(op), .funct(funct), .valid(valid),
        .stall(stall), .flush(flush),
        .bneD(bneD), .Jreg(Jreg), .Jump(Jump), .MemReadD(MemReadD),
        .JalWrite(JalWrite), .SftD(SftD), .RegWriteD(RegWriteD),
        .MemtoRegD(MemtoRegD), .MemWriteD(MemWriteD), .BranchD(BranchD),
        .ALUctrD(ALUctrD), .ALUSrcD(ALUSrcD), .RegDstD(RegDstD),
        .EndD(EndD), .LuiD(LuiD), .illegal(illegal), .halt(halt)
    );

    pipe_ctrl_unit #(.ALUW(ALUW), .DRAIN(4), .EXT_EN(0)) u_dut_noext (
        .clk(clk), .rst(rst), .op(op), .funct(funct), .valid(valid),
        .stall(stall), .flush(flush),
        .bneD(bneD2), .Jreg(Jreg2), .Jump(Jump2), .MemReadD(MemReadD2),
        .JalWrite(JalWrite2), .SftD(SftD2), .RegWriteD(RegWriteD2),
        .MemtoRegD(MemtoRegD2), .MemWriteD(MemWriteD2), .BranchD(BranchD2),
        .ALUctrD(ALUctrD2), .ALUSrcD(ALUSrcD2), .RegDstD(RegDstD2),
        .EndD(EndD2), .LuiD(LuiD2), .illegal(illegal2), .halt(halt2)
    );

    always #5 clk = ~clk;

    wire [13:0] act_flags = {bneD, Jreg, Jump, MemReadD, JalWrite, SftD, RegWriteD,
                             MemtoRegD, MemWriteD, BranchD, ALUSrcD, RegDstD, EndD, LuiD};
    wire [13:0] act_flags2 = {bneD2, Jreg2, Jump2, MemReadD2, JalWrite2, SftD2, RegWriteD2,
                              MemtoRegD2, MemWriteD2, BranchD2, ALUSrcD2, RegDstD2, EndD2, LuiD2};

    typedef struct {
        logic [5:0]  op;
        logic [5:0]  funct;
        logic        valid;
        logic        stall;
        logic        flush;
        logic [13:0] flags;
        logic [3:0]  alu;
        logic        ill;
        string       name;
    } vec_t;

    typedef struct {
        logic [13:0] flags;
        logic [3:0]  alu;
        logic        ill;
        logic        halt;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    vec_t tbl[35];

    function automatic vec_t mk(input logic [5:0] o, input logic [5:0] f,
                                input logic v, input logic s, input logic fl,
                                input logic [13:0] ef, input logic [3:0] ea,
                                input logic ei, input string nm);
        vec_t r;
        r.op = o; r.funct = f; r.valid = v; r.stall = s; r.flush = fl;
        r.flags = ef; r.alu = ea; r.ill = ei; r.name = nm;
        return r;
    endfunction

    task automatic push_exp(input logic [13:0] ef, input logic [3:0] ea,
                            input logic ei, input logic eh, input string nm);
        exp_t e;
        e.flags = ef; e.alu = ea; e.ill = ei; e.halt = eh; e.name = nm;
        sb.push_back(e);
    endtask

    task automatic compare_pop();
        exp_t e;
        n_checks++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard: no expected entry queued");
            return;
        end
        e = sb.pop_front();
        if ({act_flags, ALUctrD, illegal, halt} !== {e.flags, e.alu, e.ill, e.halt}) begin
            n_fail++;
            $display("FAIL %s: got flags=%b alu=%0d illegal=%b halt=%b, expected flags=%b alu=%0d illegal=%b halt=%b",
                     e.name, act_flags, ALUctrD, illegal, halt, e.flags, e.alu, e.ill, e.halt);
        end
    endtask

    // Drive one edge's worth of stimulus and check the resulting bundle
    task automatic step(input logic [5:0] o, input logic [5:0] f, input logic v,
                        input logic s, input logic fl, input logic [13:0] ef,
                        input logic [3:0] ea, input logic ei, input logic eh,
                        input string nm);
        @(negedge clk);
        op = o; funct = f; valid = v; stall = s; flush = fl;
        push_exp(ef, ea, ei, eh, nm);
        @(posedge clk);
        #1;
        compare_pop();
    endtask

    task automatic expect_now(input logic [13:0] ef, input logic [3:0] ea,
                              input logic ei, input logic eh, input string nm);
        push_exp(ef, ea, ei, eh, nm);
        compare_pop();
    endtask

    task automatic check_noext(input string nm, input logic [13:0] ef,
                               input logic [3:0] ea, input logic ei);
        n_checks++;
        if ({act_flags2, ALUctrD2, illegal2} !== {ef, ea, ei}) begin
            n_fail++;
            $display("FAIL %s: got flags=%b alu=%0d illegal=%b, expected flags=%b alu=%0d illegal=%b",
                     nm, act_flags2, ALUctrD2, illegal2, ef, ea, ei);
        end
    endtask

    // Assert reset between edges with a quiet input bus, check the clear
    // happens without a clock, then release on a falling edge.
    task automatic async_reset(input string nm);
        #2;
        valid = 1'b0; stall = 1'b0; flush = 1'b0;
        rst = 1'b0;
        #1;
        expect_now(c_NONE, 4'd0, 1'b0, 1'b0, nm);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = mk(6'b000000, 6'b100000, 1, 0, 0, c_RR, 4'd0, 0, "add");
        tbl[1]  = mk(6'b000000, 6'b100010, 1, 0, 0, c_RR, 4'd1, 0, "sub");
        tbl[2]  = mk(6'b000000, 6'b100100, 1, 0, 0, c_RR, 4'd2, 0, "and");
        tbl[3]  = mk(6'b000000, 6'b100111, 1, 0, 0, c_RR, 4'd3, 0, "nor");
        tbl[4]  = mk(6'b000000, 6'b100101, 1, 0, 0, c_RR, 4'd4, 0, "or");
        tbl[5]  = mk(6'b000000, 6'b100110, 1, 0, 0, c_RR, 4'd5, 0, "xor");
        tbl[6]  = mk(6'b000000, 6'b101010, 1, 0, 0, c_RR, 4'd9, 0, "slt");
        tbl[7]  = mk(6'b000000, 6'b000100, 1, 0, 0, c_RR, 4'd6, 0, "sllv");
        tbl[8]  = mk(6'b000000, 6'b000011, 1, 0, 0, c_RR | c_SFT, 4'd8, 0, "sra");
        tbl[9]  = mk(6'b000000, 6'b000010, 1, 0, 0, c_RR | c_SFT, 4'd7, 0, "srl");
        tbl[10] = mk(6'b000000, 6'b001000, 1, 0, 0, c_JREG, 4'd0, 0, "jr");
        tbl[11] = mk(6'b000000, 6'b001001, 1, 0, 0, c_JREG | c_JAL | c_RW, 4'd0, 0, "jalr");
        tbl[12] = mk(6'b001000, 6'b000000, 1, 0, 0, c_SRC | c_RW, 4'd0, 0, "addi");
        tbl[13] = mk(6'b001100, 6'b000000, 1, 0, 0, c_SRC | c_RW, 4'd2, 0, "andi");
        tbl[14] = mk(6'b001101, 6'b000000, 1, 0, 0, c_SRC | c_RW, 4'd4, 0, "ori");
        tbl[15] = mk(6'b001110, 6'b000000, 1, 0, 0, c_SRC | c_RW, 4'd5, 0, "xori");
        tbl[16] = mk(6'b001010, 6'b000000, 1, 0, 0, c_SRC | c_RW, 4'd9, 0, "slti");
        tbl[17] = mk(6'b001111, 6'b000000, 1, 0, 0, c_LUI | c_SRC | c_RW, 4'd0, 0, "lui");
        tbl[18] = mk(6'b100011, 6'b000000, 1, 0, 0, c_MR | c_RW | c_M2R | c_SRC, 4'd0, 0, "lw");
        tbl[19] = mk(6'b101011, 6'b000000, 1, 1, 0, c_MR | c_RW | c_M2R | c_SRC, 4'd0, 0, "lw held stall1");
        tbl[20] = mk(6'b101011, 6'b000000, 1, 1, 0, c_MR | c_RW | c_M2R | c_SRC, 4'd0, 0, "lw held stall2");
        tbl[21] = mk(6'b101011, 6'b000000, 1, 1, 0, c_MR | c_RW | c_M2R | c_SRC, 4'd0, 0, "lw held stall3");
        tbl[22] = mk(6'b101011, 6'b000000, 1, 0, 0, c_MW | c_SRC, 4'd0, 0, "sw after stall");
        tbl[23] = mk(6'b000100, 6'b000000, 1, 0, 0, c_BR, 4'd1, 0, "beq");
        tbl[24] = mk(6'b000101, 6'b000000, 1, 0, 0, c_BR | c_BNE | c_RD, 4'd10, 0, "bne");
        tbl[25] = mk(6'b000010, 6'b000000, 1, 0, 0, c_JMP, 4'd0, 0, "j");
        tbl[26] = mk(6'b000011, 6'b000000, 1, 0, 0, c_JMP | c_JAL | c_RW, 4'd0, 0, "jal");
        tbl[27] = mk(6'b011111, 6'b000000, 1, 0, 0, c_NONE, 4'd0, 1, "illegal op");
        tbl[28] = mk(6'b000000, 6'b100000, 0, 0, 0, c_NONE, 4'd0, 0, "valid0 bubble");
        tbl[29] = mk(6'b000000, 6'b111111, 1, 0, 0, c_NONE, 4'd0, 1, "illegal funct");
        tbl[30] = mk(6'b000000, 6'b100000, 1, 0, 0, c_RR, 4'd0, 0, "add before flush");
        tbl[31] = mk(6'b000000, 6'b100000, 1, 1, 1, c_NONE, 4'd0, 0, "stall+flush");
        tbl[32] = mk(6'b011111, 6'b000000, 1, 0, 1, c_NONE, 4'd0, 0, "flush over illegal");
        tbl[33] = mk(6'b011111, 6'b000000, 1, 0, 0, c_NONE, 4'd0, 1, "illegal again");
        tbl[34] = mk(6'b011111, 6'b000000, 1, 1, 0, c_NONE, 4'd0, 0, "illegal under stall");

        // Reset state before any clock edge
        #2;
        expect_now(c_NONE, 4'd0, 1'b0, 1'b0, "reset state");
        @(negedge clk);
        rst = 1'b1;

        // Decode table
        for (int i = 0; i < 35; i++) begin
            step(tbl[i].op, tbl[i].funct, tbl[i].valid, tbl[i].stall, tbl[i].flush,
                 tbl[i].flags, tbl[i].alu, tbl[i].ill, 1'b0, tbl[i].name);
        end

        // Extension decode on and off side by side
        step(6'b001111, 6'b000000, 1, 0, 0, c_LUI | c_SRC | c_RW, 4'd0, 0, 0, "lui ext");
        check_noext("lui noext", c_NONE, 4'd0, 1'b1);
        step(6'b001010, 6'b000000, 1, 0, 0, c_SRC | c_RW, 4'd9, 0, 0, "slti ext");
        check_noext("slti noext", c_NONE, 4'd0, 1'b1);
        step(6'b000000, 6'b001001, 1, 0, 0, c_JREG | c_JAL | c_RW, 4'd0, 0, 0, "jalr ext");
        check_noext("jalr noext", c_NONE, 4'd0, 1'b1);
        step(6'b000000, 6'b100000, 1, 0, 0, c_RR, 4'd0, 0, 0, "add ext");
        check_noext("add noext", c_RR, 4'd0, 1'b0);

        // End, then add every cycle: 4 bubbles, halt from 5th cycle on
        step(6'b111111, 6'b000000, 1, 0, 0, c_END, 4'd0, 0, 0, "end");
        for (int i = 1; i <= 4; i++)
            step(6'b000000, 6'b100000, 1, 0, 0, c_NONE, 4'd0, 0, 0, $sformatf("drain bubble %0d", i));
        for (int i = 5; i <= 7; i++)
            step(6'b000000, 6'b100000, 1, 0, 0, c_NONE, 4'd0, 0, 1, $sformatf("halted cycle %0d", i));
        step(6'b000000, 6'b100000, 1, 0, 1, c_NONE, 4'd0, 0, 1, "halt ignores flush");

        // Reset from HALT clears halt without a clock
        async_reset("reset in halt");
        step(6'b000000, 6'b100010, 1, 0, 0, c_RR, 4'd1, 0, 0, "sub after halt reset");

        // Reset mid-DRAIN while EndD is showing
        step(6'b111111, 6'b000000, 1, 0, 0, c_END, 4'd0, 0, 0, "end before reset");
        step(6'b000000, 6'b100000, 1, 0, 0, c_NONE, 4'd0, 0, 0, "drain before reset");
        async_reset("reset in drain");
        step(6'b000000, 6'b100000, 1, 0, 0, c_RR, 4'd0, 0, 0, "add after drain reset");

        // Stall freezes drain counter, flush does not advance it twice
        step(6'b111111, 6'b000000, 1, 0, 0, c_END, 4'd0, 0, 0, "end 2");
        step(6'b111111, 6'b000000, 1, 1, 0, c_END, 4'd0, 0, 0, "end held by stall");
        step(6'b000000, 6'b100000, 1, 0, 0, c_NONE, 4'd0, 0, 0, "drain2 e1");
        step(6'b000000, 6'b100000, 1, 1, 0, c_NONE, 4'd0, 0, 0, "drain2 stalled");
        step(6'b000000, 6'b100000, 1, 0, 1, c_NONE, 4'd0, 0, 0, "drain2 flush");
        step(6'b000000, 6'b100000, 1, 0, 0, c_NONE, 4'd0, 0, 0, "drain2 e3");
        step(6'b000000, 6'b100000, 1, 0, 0, c_NONE, 4'd0, 0, 0, "drain2 e4");
        step(6'b000000, 6'b100000, 1, 0, 0, c_NONE, 4'd0, 0, 1, "drain2 halt");

        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard: %0d expected entries left unchecked", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_ctrl_unit.md
PIPE_CTRL_UNIT -- requirements
Module: pipe_ctrl_unit

Interface
REQ-001 Parameter ALUW, default 4: width of ALUctrD; SHALL be >= 4.
REQ-002 Parameter DRAIN, default 4: cycles of bubble issued after an end instruction before halt; SHALL be 1..255.
REQ-003 Parameter EXT_EN, default 1: 1 enables decode of slti, lui and jalr; 0 treats them as illegal.
REQ-004 Clock and reset SHALL be: one clock; reset is asynchronous and active-low.
REQ-005 clk  input  1  clock; all state updates on rising edge.
REQ-006 rst  input  1  asynchronous active-low reset.
REQ-007 op  input  6  opcode of the instruction in decode.
REQ-008 funct  input  6  funct field of the instruction in decode.
REQ-009 valid  input  1  op/funct hold a real instruction; 0 means decode a bubble.
REQ-010 stall  input  1  hold all registered outputs.
REQ-011 flush  input  1  replace the next registered bundle with a bubble.
REQ-012 Outputs (all registered, 1 bit unless stated): bneD, Jreg, Jump, MemReadD, JalWrite, SftD, RegWriteD, MemtoRegD, MemWriteD, BranchD, ALUctrD[ALUW], ALUSrcD, RegDstD, EndD, LuiD.
REQ-013 illegal  output  1  one-cycle pulse: unrecognised valid instruction was decoded.
REQ-014 halt  output  1  level: program finished and pipeline drained.

Function
REQ-015 Latency SHALL be exactly 1 cycle: a bundle decoded from op/funct sampled at edge k SHALL appear on the outputs after edge k.
REQ-016 Bubble SHALL be all bundle outputs 0; ALUctrD is zero-extended to ALUW in every case.
REQ-017 ALU codes SHALL be: add 0, sub 1, and 2, nor 3, or 4, xor 5, sll 6, srl 7, sra 8, slt 9, bne-compare 10.
REQ-018 R-type (op 000000): add/addu ALU0, sub/subu ALU1, and 2, nor 3, or 4, xor 5, slt 9, sllv 6, srlv 7, srav 8; each RegWriteD=1, RegDstD=1.
REQ-019 sll/srl/sra SHALL be as sllv/srlv/srav with SftD=1 in addition.
REQ-020 jr (funct 001000) SHALL be Jreg=1 only; jalr (funct 001001, EXT_EN=1) SHALL be Jreg=1, JalWrite=1, RegWriteD=1.
REQ-021 I-type: addi/addiu ALU0, andi 2, ori 4, xori 5; each ALUSrcD=1, RegWriteD=1.
REQ-022 slti (001010, EXT_EN=1): ALU9, ALUSrcD=1, RegWriteD=1; lui (001111, EXT_EN=1): LuiD=1, ALUSrcD=1, RegWriteD=1.
REQ-023 lw: MemReadD, RegWriteD, MemtoRegD, ALUSrcD=1, ALU0; sw: MemWriteD, ALUSrcD=1, ALU0.
REQ-024 beq: BranchD=1, ALU1; bne: BranchD=1, bneD=1, RegDstD=1, ALU10.
REQ-025 j: Jump=1; jal: Jump=1, JalWrite=1, RegWriteD=1.
REQ-026 end (111111): EndD=1 only.
REQ-027 Any other valid op/funct (including op 000000 funct 111111) SHALL load a bubble and pulse illegal for 1 cycle.
REQ-028 valid=0 SHALL load a bubble without pulsing illegal.
REQ-029 Priority per edge SHALL be: flush > stall > decode; flush overrides stall and loads a bubble.
REQ-030 stall=1 (no flush) SHALL hold all bundle outputs; illegal SHALL be 0 during stall.
REQ-031 FSM states SHALL be RUN, DRAIN, HALT; reset state RUN.
REQ-032 RUN -> DRAIN on an edge that loads EndD=1 (valid end, no stall, no flush); counter loads DRAIN.
REQ-033 In DRAIN the block SHALL load bubbles regardless of inputs, decrement the counter each non-stalled edge, and go to HALT when the counter reaches 1 at a non-stalled edge.
REQ-034 In HALT: halt=1, bubbles loaded, inputs ignored, state held until reset.
REQ-035 flush in DRAIN/HALT SHALL have no effect on state or counter; stall in DRAIN SHALL freeze the counter.
REQ-036 EndD SHALL be high for exactly one non-stalled cycle per end instruction.

Reset
REQ-037 rst low SHALL immediately, without clk, clear all outputs to 0, state to RUN, counter to 0.
REQ-038 Reset asserted mid-DRAIN or in HALT SHALL return to RUN; first decode occurs at the first rising edge after rst rises.

Verification
REQ-039 op=000000 funct=100010 valid=1 -> next cycle RegWriteD=1, RegDstD=1, ALUctrD=1, all others 0.
REQ-040 lw then stall=1 for 3 cycles with op changed to sw -> lw bundle (MemReadD=1, MemtoRegD=1) held 3 cycles, then sw bundle.
REQ-041 stall=1 and flush=1 same edge over add -> bubble loaded, illegal=0.
REQ-042 op=011111 valid=1 -> bubble, illegal=1 for one cycle; EXT_EN=0 with lui -> illegal=1.
REQ-043 DRAIN=4, end decoded, then add every cycle -> EndD 1 cycle, 4 bubble cycles, halt=1 from the 5th cycle after EndD onward.
REQ-044 rst pulsed low in DRAIN -> outputs 0 at once, halt=0, next add decodes normally.
